mem_access_unit: RTL and testbench

//  Memory-phase responder for the multi-cycle core sequencer. Starts on the one-cycle memory-phase enable from the control unit.

---
 rtl/mau_pkg.sv | 27 ++
 rtl/lane_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared size codes, FSM encodings and command legality check for the memory access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    // Reserved size and lane-crossing accesses are rejected before any request.
    function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: byte enables, replicated store data and extended load data.
module lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mrdata,
    output logic [3:0]  mbe,
    output logic [31:0] mwdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mrdata >> {addr_lo, 3'b000};
        mbe     = 4'b1111;
        mwdata  = wdata;
        ldata   = mrdata;
        case (size)
            SZ_BYTE: begin
                mbe    = 4'b0001 << addr_lo;
                mwdata = {4{wdata[7:0]}};
                ldata  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mbe    = 4'b0011 << addr_lo;
                mwdata = {2{wdata[15:0]}};
                ldata  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                mbe    = 4'b1111;
                mwdata = wdata;
                ldata  = mrdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-phase responder: runs one load/store over a req/ack handshake and reports done or error.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_en,
    input  logic              I_we,
    input  logic [1:0]        I_size,
    input  logic              I_signed,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [31:0]       I_wdata,
    output logic [31:0]       O_rdata,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_err,
    output logic              O_mreq,
    output logic              O_mwe,
    output logic [ADDR_W-1:0] O_maddr,
    output logic [31:0]       O_mwdata,
    output logic [3:0]        O_mbe,
    input  logic              I_mack,
    input  logic [31:0]       I_mrdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              in_req;
    logic [3:0]        lane_mbe;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_ldata;

    lane_align u_lane_align (
        .size     (size_q),
        .sign_ext (signed_q),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .mrdata   (I_mrdata),
        .mbe      (lane_mbe),
        .mwdata   (lane_wdata),
        .ldata    (lane_ldata)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (I_en) begin
                    if (cmd_legal(I_size, I_addr[1:0])) begin
                        we_d     = I_we;
                        size_d   = I_size;
                        signed_d = I_signed;
                        addr_d   = I_addr;
                        wdata_d  = I_wdata;
                        cnt_d    = '0;
                        state_d  = ST_REQ;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (I_mack) begin
                    if (!we_q) rdata_d = lane_ldata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign in_req   = (state_q == ST_REQ);
    assign O_mreq   = in_req;
    assign O_busy   = in_req;
    assign O_done   = (state_q == ST_DONE);
    assign O_err    = (state_q == ST_ERR);
    assign O_rdata  = rdata_q;
    assign O_mwe    = in_req & we_q;
    assign O_maddr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign O_mwdata = in_req ? lane_wdata : 32'h0;
    assign O_mbe    = in_req ? lane_mbe : 4'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a result scoreboard and immediate-assertion checks.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        mack;
    logic [31:0] mrdata;

    typedef struct {
        string       tag;
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rdata_model = 32'h0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .I_clk    (clk),
        .I_reset  (rst),
        .I_en     (en),
        .I_we     (we),
        .I_size   (size),
        .I_signed (sgn),
        .I_addr   (addr),
        .I_wdata  (wdata),
        .O_rdata  (rdata),
        .O_busy   (busy),
        .O_done   (done),
        .O_err    (err),
        .O_mreq   (mreq),
        .O_mwe    (mwe),
        .O_maddr  (maddr),
        .O_mwdata (mwdata),
        .O_mbe    (mbe),
        .I_mack   (mack),
        .I_mrdata (mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic is_err);
        exp_t e;
        e.tag    = tag;
        e.is_err = is_err;
        e.rdata  = rdata_model;
        exp_q.push_back(e);
    endtask

    // Drives a one-cycle enable; returns just after the sampling edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; size = sz; sgn = s; addr = a; wdata = d; en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mack = 1'b1; mrdata = d;
        step();
        mack = 1'b0; mrdata = 32'h0;
    endtask

    task automatic wait_result(output int waited);
        exp_t e;
        waited = 0;
        while (!(done || err) && waited < 40) begin
            step();
            waited++;
        end
        if (!(done || err)) begin
            chk("result_timeout", {30'h0, done, err}, 32'h1);
        end else if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_err"}, {31'h0, err}, {31'h0, e.is_err});
            chk({e.tag, "_done"}, {31'h0, done}, {31'h0, ~e.is_err});
            chk({e.tag, "_rdata"}, rdata, e.rdata);
            step();
            chk({e.tag, "_pulse"}, {30'h0, done, err}, 32'h0);
        end
    endtask

    initial begin
        int w;
        int n;
        rst = 1'b1; en = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = 32'h0; wdata = 32'h0; mack = 1'b0; mrdata = 32'h0;
        step();
        step();
        chk("rst_outs", {26'h0, mreq, busy, done, err, mwe, 1'b0}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mbe_maddr", {28'h0, mbe} | maddr, 32'h0);
        rst = 1'b0;
        step();

        // Word store, ack one cycle after request.
        push_exp("st_word", 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("st_word_req", {30'h0, mreq, busy}, 32'h3);
        chk("st_word_mwe", {31'h0, mwe}, 32'h1);
        chk("st_word_maddr", maddr, 32'h0000_0100);
        chk("st_word_mbe", {28'h0, mbe}, 32'hF);
        chk("st_word_mwdata", mwdata, 32'hDEAD_BEEF);
        ack(32'h1234_5678);
        wait_result(w);
        chk("st_word_latency", w, 0);

        // Signed byte load from lane 3.
        push_exp("ld_sb", 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        chk("ld_sb_mbe", {28'h0, mbe}, 32'h8);
        chk("ld_sb_maddr", maddr, 32'h0000_0100);
        chk("ld_sb_mwe", {31'h0, mwe}, 32'h0);
        rdata_model = 32'hFFFF_FF80;
        exp_q[exp_q.size()-1].rdata = rdata_model;
        ack(32'h80FF_FFFF);
        wait_result(w);

        // Unsigned byte load, same lane.
        rdata_model = 32'h0000_0080;
        push_exp("ld_ub", 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        ack(32'h80FF_FFFF);
        wait_result(w);

        // Unsigned half load from upper half, then signed half from lower half.
        rdata_model = 32'h0000_1234;
        push_exp("ld_uh", 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
        chk("ld_uh_mbe", {28'h0, mbe}, 32'hC);
        ack(32'h1234_5678);
        wait_result(w);
        rdata_model = 32'hFFFF_8001;
        push_exp("ld_sh", 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0);
        chk("ld_sh_mbe", {28'h0, mbe}, 32'h3);
        ack(32'h0000_8001);
        wait_result(w);

        // Byte and half stores replicate data; rdata is left alone.
        push_exp("st_byte", 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_56AB);
        chk("st_byte_mbe", {28'h0, mbe}, 32'h2);
        chk("st_byte_mwdata", mwdata, 32'hABAB_ABAB);
        ack(32'h0);
        wait_result(w);
        push_exp("st_half", 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h9999_CAFE);
        chk("st_half_mbe", {28'h0, mbe}, 32'hC);
        chk("st_half_mwdata", mwdata, 32'hCAFE_CAFE);
        chk("st_half_maddr", maddr, 32'h0000_0300);
        ack(32'h0);
        wait_result(w);

        // Illegal commands: error next cycle, no request.
        push_exp("bad_half", 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0);
        chk("bad_half_noreq", {31'h0, mreq}, 32'h0);
        wait_result(w);
        chk("bad_half_latency", w, 0);
        push_exp("bad_word", 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
        chk("bad_word_noreq", {31'h0, mreq}, 32'h0);
        wait_result(w);
        push_exp("bad_rsvd", 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        chk("bad_rsvd_noreq", {31'h0, mreq}, 32'h0);
        wait_result(w);

        // Ack withheld: request held for exactly TIMEOUT cycles.
        push_exp("timeout", 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5555_AAAA);
        n = 0;
        while (mreq && n < 40) begin
            n++;
            step();
        end
        chk("timeout_req_cycles", n, 15);
        wait_result(w);
        chk("timeout_idle", {30'h0, mreq, busy}, 32'h0);

        // Ack on the last permitted cycle completes normally.
        push_exp("late_ack", 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5555_AAAA);
        for (int i = 0; i < 14; i++) step();
        chk("late_ack_still_req", {31'h0, mreq}, 32'h1);
        ack(32'h0);
        wait_result(w);
        chk("late_ack_latency", w, 0);

        // Reset during REQ abandons the access and clears rdata.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdata_model = 32'h0;
        chk("rst_req_outs", {30'h0, mreq, busy}, 32'h0);
        chk("rst_req_rdata", rdata, 32'h0);
        rdata_model = 32'h0BAD_F00D;
        push_exp("post_rst", 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0);
        chk("post_rst_maddr", maddr, 32'h0000_0600);
        ack(32'h0BAD_F00D);
        wait_result(w);

        // Enable during REQ and ack during IDLE are ignored.
        rdata_model = 32'h0000_0042;
        push_exp("en_in_req", 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0700, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0800, 32'hFFFF_FFFF);
        chk("en_in_req_maddr", maddr, 32'h0000_0700);
        chk("en_in_req_mwe", {31'h0, mwe}, 32'h0);
        ack(32'h1111_1142);
        wait_result(w);
        mack = 1'b1; mrdata = 32'h7777_7777;
        step();
        step();
        chk("idle_ack_outs", {28'h0, mreq, busy, done, err}, 32'h0);
        chk("idle_ack_rdata", rdata, 32'h0000_0042);
        mack = 1'b0; mrdata = 32'h0;
        step();
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
